// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush controller.
// This covers the state encoding, default M-extension latencies, the hazard-cause enum
// and the NOP encoding.
package hazard_pkg;

  localparam int          DEF_MUL_LAT = 1;
  localparam int          DEF_DIV_LAT = 33;
  localparam int          DEF_CNT_W   = 6;
  localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_MULDIV = 1'b1
  } state_e;

  // Winning hazard for the current cycle. The first matching rule wins.
  typedef enum logic [2:0] {
    CAUSE_NONE     = 3'd0,
    CAUSE_RESET    = 3'd1,
    CAUSE_DMEM     = 3'd2,
    CAUSE_MULDIV   = 3'd3,
    CAUSE_BRANCH   = 3'd4,
    CAUSE_LOAD_USE = 3'd5,
    CAUSE_IMEM     = 3'd6
  } cause_e;

  // A load in EX writes a register that the instruction in ID actually reads.
  // x0 never creates a dependency.
  function automatic logic load_use_hit(
    input logic       ex_mem_read,
    input logic [4:0] ex_rd,
    input logic [4:0] id_rs1,
    input logic       id_uses_rs1,
    input logic [4:0] id_rs2,
    input logic       id_uses_rs2
  );
    logic dep;
    dep = (id_uses_rs1 && (id_rs1 == ex_rd)) || (id_uses_rs2 && (id_rs2 == ex_rd));
    return ex_mem_read && (ex_rd != 5'd0) && dep;
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-controller bus. The pipeline side drives the hazard inputs, and the
// controller returns the hold/flush strobes, debug state and stall counter.
interface pipeline_hazard_ctrl_if;
  logic [4:0]  ID_RS1;
  logic [4:0]  ID_RS2;
  logic        ID_USES_RS1;
  logic        ID_USES_RS2;
  logic [4:0]  EX_RD;
  logic        EX_MEM_READ;
  logic        EX_MULDIV;
  logic        EX_IS_DIV;
  logic        EX_BRANCH_TAKEN;
  logic        IMEM_BUSYWAIT;
  logic        DMEM_BUSYWAIT;
  logic        PC_HOLD;
  logic        IF_ID_HOLD;
  logic        IF_ID_FLUSH;
  logic        ID_EX_HOLD;
  logic        ID_EX_FLUSH;
  logic        EX_MEM_HOLD;
  logic        EX_MEM_FLUSH;
  logic        CTRL_STATE;
  logic [31:0] STALL_COUNT;

  modport master (
    output ID_RS1, ID_RS2, ID_USES_RS1, ID_USES_RS2, EX_RD, EX_MEM_READ,
           EX_MULDIV, EX_IS_DIV, EX_BRANCH_TAKEN, IMEM_BUSYWAIT, DMEM_BUSYWAIT,
    input  PC_HOLD, IF_ID_HOLD, IF_ID_FLUSH, ID_EX_HOLD, ID_EX_FLUSH,
           EX_MEM_HOLD, EX_MEM_FLUSH, CTRL_STATE, STALL_COUNT
  );

  modport slave (
    input  ID_RS1, ID_RS2, ID_USES_RS1, ID_USES_RS2, EX_RD, EX_MEM_READ,
           EX_MULDIV, EX_IS_DIV, EX_BRANCH_TAKEN, IMEM_BUSYWAIT, DMEM_BUSYWAIT,
    output PC_HOLD, IF_ID_HOLD, IF_ID_FLUSH, ID_EX_HOLD, ID_EX_FLUSH,
           EX_MEM_HOLD, EX_MEM_FLUSH, CTRL_STATE, STALL_COUNT
  );
endinterface

// File: rtl/pipeline_hazard_ctrl_chk.sv
// Simulation-only sanity properties for the hazard controller.
module pipeline_hazard_ctrl_chk (
  input logic       CLK,
  input logic       RESET,
  input logic       EX_MULDIV,
  input logic       EX_BRANCH_TAKEN,
  input logic [2:0] hold_s,
  input logic [2:0] flush_s
);
  // An M-extension op never resolves as a taken branch
  a_no_muldiv_branch: assert property (@(posedge CLK) disable iff (RESET)
    !(EX_MULDIV && EX_BRANCH_TAKEN));

  // No pipeline register is frozen and bubbled in the same cycle
  a_hold_flush_excl: assert property (@(posedge CLK)
    ((hold_s & flush_s) == 3'b000));
endmodule

// File: rtl/pipeline_hazard_ctrl_sat_counter32.sv
// 32-bit event counter with synchronous clear that sticks at all-ones.
module sat_counter32 (
  input  logic        CLK,
  input  logic        srst,
  input  logic        en,
  output logic [31:0] count
);
  logic [31:0] count_q;
  logic [31:0] count_d;

  // Next count: clear, saturating increment, or hold
  always_comb begin
    count_d = count_q;
    if (srst) begin
      count_d = 32'h0000_0000;
    end else if (en && (count_q != 32'hFFFF_FFFF)) begin
      count_d = count_q + 32'd1;
    end else begin
      count_d = count_q;
    end
  end

  // Count register
  always_ff @(posedge CLK) begin
    count_q <= count_d;
  end

  assign count = count_q;
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush controller for the 5-stage RV32IM pipeline.
// Hold/flush strobes are Mealy outputs of the current state and inputs.
// Multi-cycle MUL/DIV occupancy of EX is tracked by a down-counter.
module pipeline_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int MUL_LAT = DEF_MUL_LAT,
  parameter int DIV_LAT = DEF_DIV_LAT,
  parameter int CNT_W   = DEF_CNT_W
) (
  input logic                   CLK,
  input logic                   RESET,
  pipeline_hazard_ctrl_if.slave hz
);
  state_e           state_q;
  state_e           state_d;
  logic [CNT_W-1:0] occ_q;
  logic [CNT_W-1:0] occ_d;
  logic [CNT_W-1:0] lat_s;
  logic             load_use_s;
  cause_e           cause_s;
  // {PC_H, IF_ID_H, IF_ID_F, ID_EX_H, ID_EX_F, EX_MEM_H, EX_MEM_F}
  logic [6:0]       strobe_s;

  assign lat_s      = hz.EX_IS_DIV ? CNT_W'(DIV_LAT) : CNT_W'(MUL_LAT);
  assign load_use_s = load_use_hit(hz.EX_MEM_READ, hz.EX_RD, hz.ID_RS1, hz.ID_USES_RS1,
                                   hz.ID_RS2, hz.ID_USES_RS2);

  // Priority-select the hazard cause and compute the next state/occupancy
  always_comb begin
    cause_s = CAUSE_NONE;
    state_d = state_q;
    occ_d   = occ_q;
    if (RESET) begin
      cause_s = CAUSE_RESET;
      state_d = ST_RUN;
      occ_d   = {CNT_W{1'b0}};
    end else if (hz.DMEM_BUSYWAIT) begin
      cause_s = CAUSE_DMEM;
    end else if (state_q == ST_MULDIV) begin
      if (occ_q > CNT_W'(1)) begin
        cause_s = CAUSE_MULDIV;
        occ_d   = occ_q - CNT_W'(1);
      end else begin
        // Last EX cycle of the M op: release without any stall
        state_d = ST_RUN;
        occ_d   = {CNT_W{1'b0}};
      end
    end else if (hz.EX_MULDIV && (lat_s > CNT_W'(1))) begin
      // The first EX cycle is this one, so L-1 cycles remain
      cause_s = CAUSE_MULDIV;
      state_d = ST_MULDIV;
      occ_d   = lat_s - CNT_W'(1);
    end else if (hz.EX_BRANCH_TAKEN) begin
      cause_s = CAUSE_BRANCH;
    end else if (load_use_s) begin
      cause_s = CAUSE_LOAD_USE;
    end else if (hz.IMEM_BUSYWAIT) begin
      cause_s = CAUSE_IMEM;
    end else begin
      cause_s = CAUSE_NONE;
    end
  end

  // Map the winning cause to the hold/flush strobes
  always_comb begin
    strobe_s = 7'b000_0000;
    case (cause_s)
      CAUSE_RESET:    strobe_s = 7'b001_0101;
      CAUSE_DMEM:     strobe_s = 7'b110_1010;
      CAUSE_MULDIV:   strobe_s = 7'b110_1001;
      CAUSE_BRANCH:   strobe_s = 7'b001_0100;
      CAUSE_LOAD_USE: strobe_s = 7'b110_0100;
      CAUSE_IMEM:     strobe_s = 7'b101_0000;
      default:        strobe_s = 7'b000_0000;
    endcase
  end

  // Controller state and M-op occupancy registers
  always_ff @(posedge CLK) begin
    state_q <= state_d;
    occ_q   <= occ_d;
  end

  assign hz.PC_HOLD      = strobe_s[6];
  assign hz.IF_ID_HOLD   = strobe_s[5];
  assign hz.IF_ID_FLUSH  = strobe_s[4];
  assign hz.ID_EX_HOLD   = strobe_s[3];
  assign hz.ID_EX_FLUSH  = strobe_s[2];
  assign hz.EX_MEM_HOLD  = strobe_s[1];
  assign hz.EX_MEM_FLUSH = strobe_s[0];
  assign hz.CTRL_STATE   = (state_q == ST_MULDIV);

  sat_counter32 u_stall_cnt (
    .CLK   (CLK),
    .srst  (RESET),
    .en    (strobe_s[6]),
    .count (hz.STALL_COUNT)
  );

  pipeline_hazard_ctrl_chk u_chk (
    .CLK             (CLK),
    .RESET           (RESET),
    .EX_MULDIV       (hz.EX_MULDIV),
    .EX_BRANCH_TAKEN (hz.EX_BRANCH_TAKEN),
    .hold_s          ({strobe_s[5], strobe_s[3], strobe_s[1]}),
    .flush_s         ({strobe_s[4], strobe_s[2], strobe_s[0]})
  );
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl.
// It uses directed scenarios plus randomized traffic against a behavioural model.
module tb_pipeline_hazard_ctrl;
  import hazard_pkg::*;

  localparam int MUL_LAT = 1;
  localparam int DIV_LAT = 33;

  logic CLK = 1'b0;
  logic RESET;
  int   checks = 0;
  int   failures = 0;

  pipeline_hazard_ctrl_if hif();

  pipeline_hazard_ctrl #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT), .CNT_W(6)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .hz    (hif)
  );

  always #5 CLK = ~CLK;

  logic [6:0]  dut_strb;
  logic [39:0] obs;
  assign dut_strb = {hif.PC_HOLD, hif.IF_ID_HOLD, hif.IF_ID_FLUSH, hif.ID_EX_HOLD,
                     hif.ID_EX_FLUSH, hif.EX_MEM_HOLD, hif.EX_MEM_FLUSH};
  assign obs = {dut_strb, hif.CTRL_STATE, hif.STALL_COUNT};

  // Model: is an M op still occupying EX, how many EX cycles it still has, and the stall total
  bit          m_busy = 1'b0;
  int          m_left = 0;
  logic [31:0] m_cnt  = 32'd0;

  function automatic cause_e exp_cause();
    int  lat;
    bit  dep;
    lat = hif.EX_IS_DIV ? DIV_LAT : MUL_LAT;
    dep = hif.EX_MEM_READ && (hif.EX_RD != 5'd0) &&
          ((hif.ID_USES_RS1 && hif.ID_RS1 == hif.EX_RD) ||
           (hif.ID_USES_RS2 && hif.ID_RS2 == hif.EX_RD));
    if (RESET)                          return CAUSE_RESET;
    if (hif.DMEM_BUSYWAIT)              return CAUSE_DMEM;
    if (m_busy)                         return (m_left > 1) ? CAUSE_MULDIV : CAUSE_NONE;
    if (hif.EX_MULDIV && lat > 1)       return CAUSE_MULDIV;
    if (hif.EX_BRANCH_TAKEN)            return CAUSE_BRANCH;
    if (dep)                            return CAUSE_LOAD_USE;
    if (hif.IMEM_BUSYWAIT)              return CAUSE_IMEM;
    return CAUSE_NONE;
  endfunction

  // Strobe order: PC_H, IF_ID_H, IF_ID_F, ID_EX_H, ID_EX_F, EX_MEM_H, EX_MEM_F
  function automatic logic [6:0] strobes_for(input cause_e c);
    case (c)
      CAUSE_RESET:    return 7'b0010101;
      CAUSE_DMEM:     return 7'b1101010;
      CAUSE_MULDIV:   return 7'b1101001;
      CAUSE_BRANCH:   return 7'b0010100;
      CAUSE_LOAD_USE: return 7'b1100100;
      CAUSE_IMEM:     return 7'b1010000;
      default:        return 7'b0000000;
    endcase
  endfunction

  function automatic logic [39:0] expected();
    return {strobes_for(exp_cause()), m_busy, m_cnt};
  endfunction

  // Advance one clock and update the model from the inputs seen at that edge
  task automatic tick();
    cause_e     c;
    logic [6:0] s;
    int         lat;
    bit         md;
    bit         rst;
    c   = exp_cause();
    s   = strobes_for(c);
    lat = hif.EX_IS_DIV ? DIV_LAT : MUL_LAT;
    md  = hif.EX_MULDIV;
    rst = RESET;
    @(posedge CLK);
    if (rst) begin
      m_busy = 1'b0; m_left = 0; m_cnt = 32'd0;
    end else begin
      if (s[6] && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
      if (c != CAUSE_DMEM) begin
        if (m_busy) begin
          if (m_left > 1) m_left = m_left - 1;
          else begin m_busy = 1'b0; m_left = 0; end
        end else if (md && lat > 1) begin
          m_busy = 1'b1; m_left = lat - 1;
        end
      end
    end
    #1;
  endtask

  task automatic idle();
    hif.ID_RS1 = 5'd0; hif.ID_RS2 = 5'd0; hif.ID_USES_RS1 = 1'b0; hif.ID_USES_RS2 = 1'b0;
    hif.EX_RD = 5'd0; hif.EX_MEM_READ = 1'b0; hif.EX_MULDIV = 1'b0; hif.EX_IS_DIV = 1'b0;
    hif.EX_BRANCH_TAKEN = 1'b0; hif.IMEM_BUSYWAIT = 1'b0; hif.DMEM_BUSYWAIT = 1'b0;
  endtask

  task automatic test_reset();
    RESET = 1'b1; idle();
    #4; checks++;
    if (obs !== expected()) begin failures++; $display("FAIL reset_model: got=%h exp=%h", obs, expected()); end
    checks++;
    if (dut_strb !== 7'b0010101 || hif.STALL_COUNT !== 32'd0 || hif.CTRL_STATE !== 1'b0) begin
      failures++; $display("FAIL reset_outputs: got strb=%b cnt=%h st=%b exp strb=0010101 cnt=0 st=0",
                           dut_strb, hif.STALL_COUNT, hif.CTRL_STATE);
    end
    tick();
    RESET = 1'b0;
    #4; checks++;
    if (obs !== expected()) begin failures++; $display("FAIL reset_release: got=%h exp=%h", obs, expected()); end
    tick();
  endtask

  task automatic test_load_use();
    idle();
    hif.EX_MEM_READ = 1'b1; hif.EX_RD = 5'd5; hif.ID_RS2 = 5'd5; hif.ID_USES_RS2 = 1'b1; hif.ID_RS1 = 5'd3;
    #4; checks++;
    if (obs !== expected() || dut_strb !== 7'b1100100) begin
      failures++; $display("FAIL load_use_stall: got=%h exp=%h", obs, expected());
    end
    tick();
    hif.EX_MEM_READ = 1'b0;
    #4; checks++;
    if (obs !== expected() || hif.STALL_COUNT !== 32'd1 || dut_strb !== 7'b0000000) begin
      failures++; $display("FAIL load_use_one_bubble: got=%h exp=%h cnt_exp=1", obs, expected());
    end
    tick();
    hif.EX_MEM_READ = 1'b1; hif.EX_RD = 5'd0; hif.ID_RS2 = 5'd0;
    #4; checks++;
    if (obs !== expected() || dut_strb !== 7'b0000000) begin
      failures++; $display("FAIL load_use_x0: got=%h exp=%h", obs, expected());
    end
    tick();
  endtask

  task automatic test_div();
    int hold_n;
    int state_n;
    hold_n = 0; state_n = 0;
    idle(); hif.EX_MULDIV = 1'b1; hif.EX_IS_DIV = 1'b1;
    for (int i = 0; i < DIV_LAT; i++) begin
      #4; checks++;
      if (obs !== expected()) begin failures++; $display("FAIL div_cycle%0d: got=%h exp=%h", i, obs, expected()); end
      if (dut_strb === 7'b1101001) hold_n++;
      if (hif.CTRL_STATE === 1'b1) state_n++;
      tick();
    end
    hif.EX_MULDIV = 1'b0;
    #4; checks++;
    if (hold_n != 32 || state_n != 32 || hif.CTRL_STATE !== 1'b0) begin
      failures++; $display("FAIL div_length: got holds=%0d state=%0d exp 32/32", hold_n, state_n);
    end
    tick();
  endtask

  task automatic test_mul();
    idle(); hif.EX_MULDIV = 1'b1; hif.EX_IS_DIV = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #4; checks++;
      if (obs !== expected() || dut_strb !== 7'b0000000 || hif.CTRL_STATE !== 1'b0) begin
        failures++; $display("FAIL mul_no_stall%0d: got=%h exp=%h", i, obs, expected());
      end
      tick();
    end
    idle();
  endtask

  task automatic test_dmem_occ1();
    idle(); hif.EX_MULDIV = 1'b1; hif.EX_IS_DIV = 1'b1;
    for (int i = 0; i < DIV_LAT - 1; i++) begin
      #4; checks++;
      if (obs !== expected()) begin failures++; $display("FAIL dmem_pre%0d: got=%h exp=%h", i, obs, expected()); end
      tick();
    end
    hif.DMEM_BUSYWAIT = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #4; checks++;
      if (obs !== expected() || dut_strb !== 7'b1101010 || hif.CTRL_STATE !== 1'b1) begin
        failures++; $display("FAIL dmem_freeze%0d: got=%h exp=%h", i, obs, expected());
      end
      tick();
    end
    hif.DMEM_BUSYWAIT = 1'b0;
    #4; checks++;
    if (obs !== expected() || dut_strb !== 7'b0000000 || hif.CTRL_STATE !== 1'b1) begin
      failures++; $display("FAIL dmem_release: got=%h exp=%h", obs, expected());
    end
    tick();
    hif.EX_MULDIV = 1'b0;
    #4; checks++;
    if (obs !== expected() || hif.CTRL_STATE !== 1'b0) begin
      failures++; $display("FAIL dmem_back_to_run: got=%h exp=%h", obs, expected());
    end
    tick();
  endtask

  task automatic test_branch_priority();
    idle();
    hif.EX_BRANCH_TAKEN = 1'b1; hif.IMEM_BUSYWAIT = 1'b1;
    hif.EX_MEM_READ = 1'b1; hif.EX_RD = 5'd7; hif.ID_RS1 = 5'd7; hif.ID_USES_RS1 = 1'b1;
    #4; checks++;
    if (obs !== expected() || dut_strb !== 7'b0010100) begin
      failures++; $display("FAIL branch_priority: got strb=%b exp=0010100 (model %h)", dut_strb, expected());
    end
    tick();
    idle();
  endtask

  task automatic test_reset_mid_div();
    idle(); hif.EX_MULDIV = 1'b1; hif.EX_IS_DIV = 1'b1;
    for (int i = 0; i < 16; i++) begin
      #4; checks++;
      if (obs !== expected()) begin failures++; $display("FAIL rstdiv_pre%0d: got=%h exp=%h", i, obs, expected()); end
      tick();
    end
    RESET = 1'b1;
    #4; checks++;
    if (obs !== expected() || dut_strb !== 7'b0010101) begin
      failures++; $display("FAIL rstdiv_flush: got=%h exp=%h", obs, expected());
    end
    tick();
    RESET = 1'b0; hif.EX_MULDIV = 1'b0;
    #4; checks++;
    if (obs !== expected() || hif.CTRL_STATE !== 1'b0 || hif.STALL_COUNT !== 32'd0) begin
      failures++; $display("FAIL rstdiv_cleared: got st=%b cnt=%h exp st=0 cnt=0", hif.CTRL_STATE, hif.STALL_COUNT);
    end
    tick();
  endtask

  task automatic test_saturation();
    idle();
    dut.u_stall_cnt.count_q = 32'hFFFF_FFFE;
    m_cnt = 32'hFFFF_FFFE;
    hif.IMEM_BUSYWAIT = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #4; checks++;
      if (obs !== expected()) begin failures++; $display("FAIL sat_cycle%0d: got=%h exp=%h", i, obs, expected()); end
      tick();
    end
    hif.IMEM_BUSYWAIT = 1'b0;
    #4; checks++;
    if (hif.STALL_COUNT !== 32'hFFFF_FFFF) begin
      failures++; $display("FAIL sat_hold: got=%h exp=ffffffff", hif.STALL_COUNT);
    end
    tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 800; i++) begin
      RESET                = ($urandom_range(0, 63) == 0);
      hif.DMEM_BUSYWAIT    = ($urandom_range(0, 7) == 0);
      hif.IMEM_BUSYWAIT    = ($urandom_range(0, 3) == 0);
      hif.EX_MULDIV        = ($urandom_range(0, 7) == 0);
      hif.EX_IS_DIV        = ($urandom_range(0, 3) == 0);
      hif.EX_BRANCH_TAKEN  = !hif.EX_MULDIV && ($urandom_range(0, 4) == 0);
      hif.EX_MEM_READ      = ($urandom_range(0, 2) == 0);
      hif.EX_RD            = 5'($urandom_range(0, 3));
      hif.ID_RS1           = 5'($urandom_range(0, 3));
      hif.ID_RS2           = 5'($urandom_range(0, 3));
      hif.ID_USES_RS1      = 1'($urandom_range(0, 1));
      hif.ID_USES_RS2      = 1'($urandom_range(0, 1));
      #4; checks++;
      if (obs !== expected()) begin failures++; $display("FAIL random%0d: got=%h exp=%h", i, obs, expected()); end
      tick();
    end
    RESET = 1'b0; idle();
  endtask

  initial begin
    RESET = 1'b1; idle();
    tick(); tick();
    test_reset();
    test_load_use();
    test_div();
    test_mul();
    test_dmem_occ1();
    test_branch_priority();
    test_reset_mid_div();
    test_saturation();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Central stall/flush controller for the 5-stage RV32IM pipeline.
- Drives hold (freeze) and flush (bubble) strobes for the PC and the IF/ID, ID/EX and EX/MEM pipeline registers.
- Resolves four hazard sources: load-use, taken branch/jump, multi-cycle MUL/DIV occupancy of EX, and instruction/data memory busywait.
- Keeps a saturating stall-cycle performance counter.

Parameters:
MUL_LAT, 1, EX cycles occupied by MUL/MULH* (>=1)
DIV_LAT, 33, EX cycles occupied by DIV/DIVU/REM/REMU (>=1)
CNT_W, 6, width of occupancy counter; must satisfy 2^CNT_W > max(MUL_LAT, DIV_LAT)

Ports:
CLK  in  1  clock
RESET  in  1  synchronous, active-high reset
ID_RS1  in  5  rs1 of instruction in ID
ID_RS2  in  5  rs2 of instruction in ID
ID_USES_RS1  in  1  ID instruction reads rs1
ID_USES_RS2  in  1  ID instruction reads rs2
EX_RD  in  5  rd of instruction in EX
EX_MEM_READ  in  1  EX instruction is a load
EX_MULDIV  in  1  EX instruction is an M-extension op
EX_IS_DIV  in  1  qualifies EX_MULDIV: 1=DIV/REM class, 0=MUL class
EX_BRANCH_TAKEN  in  1  branch/jump resolved taken in EX
IMEM_BUSYWAIT  in  1  instruction memory not ready
DMEM_BUSYWAIT  in  1  data memory not ready
PC_HOLD  out  1  PC keeps its value
IF_ID_HOLD  out  1  drives BUSYWAIT of IF/ID register
IF_ID_FLUSH  out  1  IF/ID loads NOP (0x00000013)
ID_EX_HOLD  out  1  ID/EX keeps its value
ID_EX_FLUSH  out  1  ID/EX loads bubble
EX_MEM_HOLD  out  1  EX/MEM keeps its value
EX_MEM_FLUSH  out  1  EX/MEM loads bubble
CTRL_STATE  out  1  0=RUN, 1=MULDIV (debug)
STALL_COUNT  out  32  cycles with PC_HOLD=1 since reset

Behaviour:
State and reset
- Registered state: state (RUN/MULDIV), occ counter (CNT_W bits), STALL_COUNT.
- All hold/flush outputs are combinational (Mealy) from the current state and inputs, valid in the same cycle.
- RESET (sampled at posedge): state<=RUN, occ<=0, STALL_COUNT<=0.
- While RESET=1: all HOLD=0, IF_ID_FLUSH=1, ID_EX_FLUSH=1, EX_MEM_FLUSH=1.

Rule priority (first match wins; all outputs not named are 0):
1. DMEM_BUSYWAIT=1: PC_HOLD, IF_ID_HOLD, ID_EX_HOLD, EX_MEM_HOLD = 1 (full freeze, no flush). occ and state frozen.
2. state=MULDIV and occ>1: PC_HOLD, IF_ID_HOLD, ID_EX_HOLD = 1; EX_MEM_FLUSH=1. occ<=occ-1.
3. state=MULDIV and occ==1: no stall. state<=RUN, occ<=0. The M instruction leaves EX at this edge.
4. state=RUN, EX_MULDIV=1, L>1, where L = EX_IS_DIV ? DIV_LAT : MUL_LAT: same outputs as rule 2. occ<=L-1, state<=MULDIV.
   - Total EX residency is exactly L cycles.
   - L==1 gives no stall and no state change.
5. EX_BRANCH_TAKEN=1: IF_ID_FLUSH=1, ID_EX_FLUSH=1; PC_HOLD=0 even if IMEM_BUSYWAIT, so the target is loaded.
6. Load-use (EX_MEM_READ && EX_RD!=0 && ((ID_USES_RS1 && ID_RS1==EX_RD) || (ID_USES_RS2 && ID_RS2==EX_RD))): PC_HOLD=1, IF_ID_HOLD=1, ID_EX_FLUSH=1. Exactly one bubble per load.
7. IMEM_BUSYWAIT=1: PC_HOLD=1, IF_ID_FLUSH=1; downstream stages advance.

Additional rules
- EX_MULDIV is sampled only in RUN. Its assertion in MULDIV is the same held instruction and is ignored.
- EX_MULDIV and EX_BRANCH_TAKEN together is illegal; assert in simulation.
- A HOLD and a FLUSH on the same register are never both 1.
- STALL_COUNT increments each non-reset cycle with PC_HOLD=1 and saturates at 0xFFFFFFFF.

Decomposition:
- Shared package hazard_pkg holds:
  - state encoding (ST_RUN, ST_MULDIV);
  - NOP_INSTR = 32'h00000013;
  - default latencies;
  - hazard-cause enum, also used by the bench scoreboard.
- One sub-module is natural: sat_counter32 (enable, synchronous reset, saturate) for STALL_COUNT. The rest is flat.

Test Plan:
- Load-use: EX_MEM_READ=1, EX_RD=5, ID_RS2=5, ID_USES_RS2=1 -> one cycle of PC_HOLD=IF_ID_HOLD=ID_EX_FLUSH=1; STALL_COUNT 0->1. Repeat with EX_RD=0 -> no stall.
- DIV (DIV_LAT=33): EX_MULDIV=EX_IS_DIV=1 held -> 32 cycles with holds=1 and EX_MEM_FLUSH=1, then release; CTRL_STATE=1 for 32 cycles. MUL with MUL_LAT=1 -> zero stall.
- DMEM_BUSYWAIT=1 for 3 cycles at occ==1 -> all four HOLDs=1, state stays MULDIV; exit on the first cycle after DMEM_BUSYWAIT drops.
- EX_BRANCH_TAKEN=1 with IMEM_BUSYWAIT=1 and a concurrent load-use match -> IF_ID_FLUSH=ID_EX_FLUSH=1, PC_HOLD=0, IF_ID_HOLD=0.
- RESET asserted mid-DIV (occ=17) -> next cycle CTRL_STATE=0, STALL_COUNT=0; all three FLUSH=1 while RESET=1.
- STALL_COUNT forced near 0xFFFFFFFE plus 3 stall cycles -> holds at 0xFFFFFFFF.
